// File: rtl/alzette_ise_seq.sv
// Sequential Alzette ARX-box instruction-set extension.
// Accepts one (x, y, imm) request, runs the four Alzette quarter-steps over
// 4/UNROLL BUSY cycles and holds the selected half in DONE until consumed.
// Optional feature macro: ALZETTE_ISE_DEC_EN adds the inverse (decrypt)
// datapath. Without it, decrypt requests complete at once with rsp_err=1.
// UNROLL must be 1, 2 or 4 so the quarter counter lands exactly on 4.
module alzette_ise_seq #(
  parameter int UNROLL = 1
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [2:0]  imm,
  input  logic        op_enc,
  input  logic        op_x,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rd,
  output logic        rsp_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] STEP = 3'(UNROLL);
  localparam logic [2:0] LAST = 3'(4 - UNROLL);

  function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] n);
    return 32'({v, v} >> n);
  endfunction

  function automatic logic [31:0] rcon(input logic [2:0] i);
    logic [31:0] c;
    case (i)
      3'd0:    c = 32'hB7E15162;
      3'd1:    c = 32'hBF715880;
      3'd2:    c = 32'h38B4DA56;
      3'd3:    c = 32'h324E7738;
      3'd4:    c = 32'hBB1185EB;
      3'd5:    c = 32'h4F7C7B57;
      3'd6:    c = 32'hCFBFA1C8;
      default: c = 32'hC2B3293D;
    endcase
    return c;
  endfunction

  // Forward quarter k: x += ror(y,r); y ^= ror(x,s); x ^= c. Returns {x, y}.
  function automatic logic [63:0] enc_q(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] c, input logic [1:0] k);
    logic [4:0]  r;
    logic [4:0]  s;
    logic [31:0] xa;
    logic [31:0] yb;
    case (k)
      2'd0:    begin r = 5'd31; s = 5'd24; end
      2'd1:    begin r = 5'd17; s = 5'd17; end
      2'd2:    begin r = 5'd0;  s = 5'd31; end
      default: begin r = 5'd24; s = 5'd16; end
    endcase
    xa = x + ror32(y, r);
    yb = y ^ ror32(xa, s);
    return {xa ^ c, yb};
  endfunction

`ifdef ALZETTE_ISE_DEC_EN
  // Inverse quarter k (rotation pairs in reverse order): undoes enc_q exactly.
  function automatic logic [63:0] dec_q(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] c, input logic [1:0] k);
    logic [4:0]  r;
    logic [4:0]  s;
    logic [31:0] xa;
    logic [31:0] yb;
    case (k)
      2'd0:    begin r = 5'd24; s = 5'd16; end
      2'd1:    begin r = 5'd0;  s = 5'd31; end
      2'd2:    begin r = 5'd17; s = 5'd17; end
      default: begin r = 5'd31; s = 5'd24; end
    endcase
    xa = x ^ c;
    yb = y ^ ror32(xa, s);
    return {xa - ror32(yb, r), yb};
  endfunction
`endif

  logic [1:0]  r_state;
  logic [2:0]  r_cnt;
  logic [31:0] r_x;
  logic [31:0] r_y;
  logic [2:0]  r_imm;
  logic        r_opx;
  logic [31:0] r_rd;
  logic        r_err;
  logic        r_alive;
`ifdef ALZETTE_ISE_DEC_EN
  logic        r_enc;
`endif

  logic [31:0]             w_c;
  logic                    w_unsup;
  logic [UNROLL:0][31:0]   w_x;
  logic [UNROLL:0][31:0]   w_y;

  assign w_c    = rcon(r_imm);
  assign w_x[0] = r_x;
  assign w_y[0] = r_y;

`ifdef ALZETTE_ISE_DEC_EN
  assign w_unsup = 1'b0;
`else
  assign w_unsup = ~op_enc;
`endif

  // Chain of UNROLL quarter-steps, starting at the current quarter index.
  for (genvar j = 0; j < UNROLL; j++) begin : g_q
    logic [1:0]  w_k;
    logic [63:0] w_e;
    assign w_k = r_cnt[1:0] + 2'(j);
    assign w_e = enc_q(w_x[j], w_y[j], w_c, w_k);
`ifdef ALZETTE_ISE_DEC_EN
    logic [63:0] w_d;
    assign w_d = dec_q(w_x[j], w_y[j], w_c, w_k);
    assign {w_x[j+1], w_y[j+1]} = r_enc ? w_e : w_d;
`else
    assign {w_x[j+1], w_y[j+1]} = w_e;
`endif
  end

  assign req_ready = (r_state == S_IDLE) && r_alive;
  assign rsp_valid = (r_state == S_DONE);
  assign rd        = r_rd;
  assign rsp_err   = r_err;

  // Holds req_ready low until the first edge after reset release.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) r_alive <= 1'b0;
    else           r_alive <= 1'b1;
  end

  // Control FSM and datapath state; flush overrides every handshake.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_imm   <= '0;
      r_opx   <= 1'b0;
      r_rd    <= '0;
      r_err   <= 1'b0;
`ifdef ALZETTE_ISE_DEC_EN
      r_enc   <= 1'b0;
`endif
    end else if (flush) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (req_valid && req_ready) begin
          r_imm <= imm;
          r_opx <= op_x;
          r_cnt <= '0;
`ifdef ALZETTE_ISE_DEC_EN
          r_enc <= op_enc;
`endif
          if (w_unsup) begin
            // Unsupported op: no computation, x/y left untouched.
            r_state <= S_DONE;
            r_rd    <= '0;
            r_err   <= 1'b1;
          end else begin
            r_x     <= rs1;
            r_y     <= rs2;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_x   <= w_x[UNROLL];
          r_y   <= w_y[UNROLL];
          r_cnt <= r_cnt + STEP;
          if (r_cnt == LAST) begin
            r_state <= S_DONE;
            r_rd    <= r_opx ? w_x[UNROLL] : w_y[UNROLL];
            r_err   <= 1'b0;
          end
        end
        S_DONE: if (rsp_ready) begin
          r_state <= S_IDLE;
          r_err   <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alzette_ise_seq.md
ALZETTE_ISE_SEQ -- requirements
Module: alzette_ise_seq

Interface
REQ-001 Parameter UNROLL, default 1, meaning the number of Alzette quarter-steps evaluated per clock; legal values 1, 2, 4.
REQ-002 g_clk  input  1  rising-edge clock.
REQ-003 g_resetn  input  1  asynchronous, active-low reset.
REQ-004 flush  input  1  synchronous abort of any in-flight operation.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  request accepted when high with req_valid.
REQ-007 rs1  input  32  x operand.
REQ-008 rs2  input  32  y operand.
REQ-009 imm  input  3  round-constant index.
REQ-010 op_enc  input  1  1 = encrypt, 0 = decrypt.
REQ-011 op_x  input  1  1 = return x half, 0 = return y half.
REQ-012 rsp_valid  output  1  result present.
REQ-013 rsp_ready  input  1  result consumed when high with rsp_valid.
REQ-014 rd  output  32  selected result half.
REQ-015 rsp_err  output  1  request was unsupported; rd is zero.

Function
REQ-016 The constant table SHALL be imm 0..7 -> B7E15162, BF715880, 38B4DA56, 324E7738, BB1185EB, 4F7C7B57, CFBFA1C8, C2B3293D.
REQ-017 Encrypt quarter k, with (r,s) in order (31,24),(17,17),(0,31),(24,16), SHALL apply x=x+ror(y,r), then y=y^ror(x,s), then x=x^c.
REQ-018 Decrypt quarter k, with (r,s) in order (24,16),(0,31),(17,17),(31,24), SHALL apply x=x^c, then y=y^ror(x,s), then x=x-ror(y,r).
REQ-019 All add/subtract operations SHALL be modulo 2^32, and ror SHALL be a 32-bit rotate right.
REQ-020 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-021 req_ready SHALL be 1 only in IDLE.
REQ-022 A request SHALL be accepted on req_valid&req_ready.
  - rs1, rs2, imm, op_enc and op_x are registered.
  - The quarter counter is cleared.
  - The FSM moves to BUSY.
REQ-023 Each BUSY cycle SHALL apply UNROLL consecutive quarters and advance the quarter counter by UNROLL.
REQ-024 The FSM SHALL enter DONE when the quarter counter reaches 4, giving rsp_valid exactly 4/UNROLL cycles after the accept edge.
REQ-025 In DONE, rsp_valid SHALL be 1, rd SHALL be x if op_x else y, and rd, rsp_valid and rsp_err SHALL stay stable until rsp_ready.
REQ-026 DONE&rsp_ready SHALL return the FSM to IDLE; no new request is accepted in that same cycle.
REQ-027 flush=1 SHALL force IDLE on the next edge from any state, deassert rsp_valid and discard the result; flush has priority over all handshakes.
REQ-028 Inputs changing while not in IDLE SHALL have no effect on the result.
REQ-029 The x and y state registers SHALL not toggle in IDLE or DONE.

Reset
REQ-030 While g_resetn=0, the FSM SHALL be IDLE and the quarter counter, x, y, rd, rsp_valid and rsp_err SHALL be 0; req_ready SHALL be 1 one edge after reset release.
REQ-031 Reset asserted mid-operation SHALL abort the operation with no response emitted.

Configuration
REQ-032 With ALZETTE_ISE_DEC_EN defined, the decrypt datapath of REQ-018 SHALL be present.
REQ-033 Without ALZETTE_ISE_DEC_EN:
  - A request with op_enc=0 SHALL go IDLE->DONE in one cycle with rd=0 and rsp_err=1.
  - Encrypt behaviour and latency SHALL be unchanged.
  - No subtractor SHALL be synthesised.

Verification
REQ-034 UNROLL=1,2,4; encrypt rs1=0x01234567, rs2=0x89ABCDEF, imm=0 -> rd equals the golden model for both op_x values; rsp_valid arrives after 4, 2 and 1 cycles respectively.
REQ-035 Round trip, all imm 0..7, random x and y: encrypt, then decrypt the (x,y) result -> rd returns the original rs1 (op_x=1) and rs2 (op_x=0).
REQ-036 Hold rsp_ready=0 for 10 cycles in DONE -> rd and rsp_valid stable, req_ready=0 throughout; rsp_ready=1 -> IDLE next edge.
REQ-037 Assert flush in the second BUSY cycle at UNROLL=1 -> no rsp_valid; the next request returns the correct golden result.
REQ-038 Pull g_resetn low mid-BUSY -> outputs 0 immediately; after release, req_ready=1 and the next operation is correct.
REQ-039 Without ALZETTE_ISE_DEC_EN, a decrypt request with rs1=0xFFFFFFFF -> rsp_valid one cycle after accept, rd=0, rsp_err=1.
